// File: rtl/matrix_scan_drv.sv
// Row-scan driver for LED dot matrices: tear-free frame buffering, programmable dwell, per-row PWM.
// Optional anti-ghost row blanking is enabled by defining MATRIX_SCAN_BLANK_EN.
module matrix_scan_drv #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_LOG2   = 8,
  parameter int PWM_BITS     = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [PWM_BITS-1:0]  brightness,
  input  logic                 oe,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      column,
  output logic                 frame_start
);

  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RIDX_W-1:0]     LAST_ROW  = RIDX_W'(ROWS - 1);
  localparam logic [DWELL_LOG2-1:0] DWELL_MAX = {DWELL_LOG2{1'b1}};

  if ((ROWS < 2) || (DWELL_LOG2 < PWM_BITS) || (BLANK_CYCLES >= (2 ** DWELL_LOG2))) begin : g_param_check
    $error("matrix_scan_drv: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [RIDX_W-1:0]       row_idx_r;
  logic [RIDX_W-1:0]       row_idx_nxt_s;
  logic [DWELL_LOG2-1:0]   dwell_cnt_r;
  logic [DWELL_LOG2-1:0]   dwell_nxt_s;
  logic [PWM_BITS-1:0]     lvl_r;
  logic [PWM_BITS-1:0]     lvl_eff_s;
  logic [ROWS*COLS-1:0]    display_r;
  logic [ROWS*COLS-1:0]    pending_r;
  logic                    pending_full_r;
  logic [ROWS-1:0]         row_r;
  logic [ROWS-1:0]         row_nxt_s;
  logic [COLS-1:0]         column_r;
  logic [COLS-1:0]         col_nxt_s;
  logic [COLS-1:0]         col_sel_s;
  logic                    frame_start_r;
  logic                    frame_start_nxt_s;
  logic                    dwell_wrap_s;
  logic                    swap_s;
  logic                    capture_s;
  logic                    pwm_on_s;
  logic                    blank_ok_s;

  assign frame_ready  = !pending_full_r && !reset;
  assign capture_s    = frame_valid && frame_ready;
  assign dwell_wrap_s = (dwell_cnt_r == DWELL_MAX);
  assign row          = row_r;
  assign column       = column_r;
  assign frame_start  = frame_start_r;

  // Brightness takes effect only at a row start and is held for the rest of the row.
  assign lvl_eff_s = (dwell_cnt_r == {DWELL_LOG2{1'b0}}) ? brightness : lvl_r;
  assign pwm_on_s  = (dwell_cnt_r[DWELL_LOG2-1 -: PWM_BITS] < lvl_eff_s);

`ifdef MATRIX_SCAN_BLANK_EN
  assign blank_ok_s = (dwell_cnt_r >= DWELL_LOG2'(BLANK_CYCLES));
`else
  assign blank_ok_s = 1'b1;
`endif

  // State register and scan counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      row_idx_r     <= {RIDX_W{1'b0}};
      dwell_cnt_r   <= {DWELL_LOG2{1'b0}};
      lvl_r         <= {PWM_BITS{1'b0}};
      row_r         <= {ROWS{1'b0}};
      column_r      <= {COLS{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      row_idx_r     <= row_idx_nxt_s;
      dwell_cnt_r   <= dwell_nxt_s;
      lvl_r         <= lvl_eff_s;
      row_r         <= row_nxt_s;
      column_r      <= col_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  // Next-state, counter advance and frame-boundary detection.
  always_comb begin
    state_nxt_s       = state_r;
    row_idx_nxt_s     = row_idx_r;
    dwell_nxt_s       = dwell_cnt_r;
    frame_start_nxt_s = 1'b0;
    swap_s            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        swap_s        = pending_full_r;
        row_idx_nxt_s = {RIDX_W{1'b0}};
        dwell_nxt_s   = {DWELL_LOG2{1'b0}};
        if (oe) begin
          state_nxt_s       = ST_SCAN;
          frame_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!oe) begin
          state_nxt_s   = ST_IDLE;
          row_idx_nxt_s = {RIDX_W{1'b0}};
          dwell_nxt_s   = {DWELL_LOG2{1'b0}};
        end else begin
          dwell_nxt_s = dwell_cnt_r + 1'b1;
          if (dwell_wrap_s && (row_idx_r == LAST_ROW)) begin
            row_idx_nxt_s     = {RIDX_W{1'b0}};
            frame_start_nxt_s = 1'b1;
            swap_s            = pending_full_r;
          end else if (dwell_wrap_s) begin
            row_idx_nxt_s = row_idx_r + 1'b1;
          end else begin
            row_idx_nxt_s = row_idx_r;
          end
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        row_idx_nxt_s = {RIDX_W{1'b0}};
        dwell_nxt_s   = {DWELL_LOG2{1'b0}};
      end
    endcase
  end

  // Row/column drive for the next cycle, gated by PWM and optional blanking.
  always_comb begin
    col_sel_s = {COLS{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      col_sel_s = col_sel_s |
                  ((row_idx_r == RIDX_W'(r)) ? display_r[r*COLS +: COLS] : {COLS{1'b0}});
    end
    if ((state_r == ST_SCAN) && oe && pwm_on_s && blank_ok_s) begin
      row_nxt_s = {{(ROWS-1){1'b0}}, 1'b1} << row_idx_r;
      col_nxt_s = col_sel_s;
    end else begin
      row_nxt_s = {ROWS{1'b0}};
      col_nxt_s = {COLS{1'b0}};
    end
  end

  // Pending/display buffers; a capture can never coincide with a swap because ready is low when full.
  always_ff @(posedge clock) begin
    if (reset) begin
      display_r      <= {(ROWS*COLS){1'b0}};
      pending_r      <= {(ROWS*COLS){1'b0}};
      pending_full_r <= 1'b0;
    end else begin
      if (swap_s) begin
        display_r <= pending_r;
      end else begin
        display_r <= display_r;
      end
      if (capture_s) begin
        pending_r      <= frame_data;
        pending_full_r <= 1'b1;
      end else if (swap_s) begin
        pending_full_r <= 1'b0;
      end else begin
        pending_full_r <= pending_full_r;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_drv.sv
// Self-checking bench for matrix_scan_drv: frame-position model plus directed literal checks.
module tb_matrix_scan_drv;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DL    = 4;
  localparam int PB    = 2;
  localparam int DWELL = 2 ** DL;
  localparam int FRAME = ROWS * DWELL;
`ifdef MATRIX_SCAN_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [ROWS*COLS-1:0] frame_data = '0;
  logic                 frame_valid = 1'b0;
  logic                 frame_ready;
  logic [PB-1:0]        brightness = '0;
  logic                 oe = 1'b0;
  logic [ROWS-1:0]      row;
  logic [COLS-1:0]      column;
  logic                 frame_start;

  matrix_scan_drv #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_LOG2(DL), .PWM_BITS(PB), .BLANK_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .brightness(brightness), .oe(oe), .row(row),
    .column(column), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: scan position is a single frame-relative cycle count.
  logic [63:0] m_disp = '0, m_pend = '0;
  bit          m_pfull = 0, m_scan = 0, started = 0;
  int          m_t = 0, m_lvl = 0;
  logic [7:0]  e_row = '0, e_col = '0;
  logic        e_fs = 1'b0;

  always @(posedge clock) begin
    int r, d;
    bit on, cap, swap;
    logic [7:0] nr, nc;
    logic nfs;
    started = 1;
    if (reset) begin
      m_disp = '0; m_pend = '0; m_pfull = 0; m_scan = 0; m_t = 0;
      e_row = '0; e_col = '0; e_fs = 1'b0;
    end else begin
      cap = frame_valid && !m_pfull;
      swap = 0; nr = '0; nc = '0; nfs = 1'b0;
      if (!m_scan) begin
        swap = m_pfull;
        if (oe) begin m_scan = 1; m_t = 0; nfs = 1'b1; end
      end else if (!oe) begin
        m_scan = 0; m_t = 0;
      end else begin
        r = m_t / DWELL;
        d = m_t % DWELL;
        if (d == 0) m_lvl = int'(brightness);
        on = (d / (2 ** (DL - PB))) < m_lvl;
        if (d < BL) on = 0;
        if (on) begin nr = 8'(1 << r); nc = m_disp[r*COLS +: COLS]; end
        m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin nfs = 1'b1; swap = m_pfull; end
      end
      if (swap) begin m_disp = m_pend; m_pfull = 0; end
      if (cap) begin m_pend = frame_data; m_pfull = 1; end
      e_row = nr; e_col = nc; e_fs = nfs;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (started) begin
      chk("row", row, e_row);
      chk("column", column, e_col);
      chk("frame_start", frame_start, e_fs);
      chk("frame_ready", frame_ready, !m_pfull && !reset);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (frame_start === 1'b1) break;
    end
    chk("wait frame_start", frame_start, 1'b1);
  endtask

  task automatic wait_row(input logic [7:0] r);
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (row === r) break;
    end
    chk("wait row", row, r);
  endtask

  initial begin
    int on_cnt, bad_cnt, fs_cnt;
    // Reset behaviour
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t1 ready in reset", frame_ready, 1'b0);
      chk("t1 row in reset", row, 8'h00);
      chk("t1 column in reset", column, 8'h00);
      chk("t1 fs in reset", frame_start, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk("t1 ready after reset", frame_ready, 1'b1);
    tick(1);
    chk("t1 no fs", frame_start, 1'b0);

    // Diagonal frame, full brightness
    frame_data = 64'h8040201008040201; frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    tick(1);
    brightness = 2'd3; oe = 1'b1;
    tick(1);
    chk("t2 fs on start", frame_start, 1'b1);
    on_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < DWELL; i++) begin
      tick(1);
      if (row == 8'h01 && column == 8'h01) on_cnt++;
      else if (row != 8'h00 || column != 8'h00) bad_cnt++;
    end
    chk("t2 row0 on cycles", on_cnt, 12 - BL);
    chk("t2 row0 stray", bad_cnt, 0);
    tick(1 + BL);
    chk("t2 row1 row", row, 8'h02);
    chk("t2 row1 column", column, 8'h02);
    fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1);
      if (frame_start) fs_cnt++;
    end
    chk("t2 fs per 256", fs_cnt, 2);

    // Tear-free double buffering
    frame_data = {8{8'h0F}}; frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    chk("t3 A pending", frame_ready, 1'b0);
    wait_fs();
    wait_row(8'h08);
    frame_data = {8{8'hF0}}; frame_valid = 1'b1;
    tick(1);
    chk("t3 ready drop", frame_ready, 1'b0);
    frame_data = {8{8'hFF}};
    tick(3);
    frame_valid = 1'b0;
    chk("t3 row3 still A", column, 8'h0F);
    wait_row(8'h80);
    chk("t3 row7 still A", column, 8'h0F);
    wait_fs();
    tick(1 + BL);
    chk("t3 row0 B row", row, 8'h01);
    chk("t3 row0 B column", column, 8'hF0);
    chk("t3 ready back", frame_ready, 1'b1);

    // Brightness zero, then mid-row change
    brightness = 2'd0;
    wait_fs();
    on_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1);
      if (row != 8'h00 || column != 8'h00) on_cnt++;
      if (frame_start) fs_cnt++;
    end
    chk("t4 dark frame", on_cnt, 0);
    chk("t4 dark fs", fs_cnt, 1);
    tick(4 * DWELL + 8);
    brightness = 2'd2;
    on_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (row == 8'h20) on_cnt++;
    end
    chk("t4 row5 duty", on_cnt, 8 - BL);

    // oe drop and restart
    brightness = 2'd3;
    wait_row(8'h20);
    tick(3);
    oe = 1'b0;
    tick(1);
    chk("t5 row off", row, 8'h00);
    chk("t5 column off", column, 8'h00);
    tick(2);
    chk("t5 idle row", row, 8'h00);
    chk("t5 idle fs", frame_start, 1'b0);
    oe = 1'b1;
    tick(1);
    chk("t5 restart fs", frame_start, 1'b1);
    tick(1 + BL);
    chk("t5 restart row", row, 8'h01);
    chk("t5 display kept", column, 8'hF0);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scan_drv.md
Name: matrix_scan_drv

Overview:
Parametrised row-scan driver for LED dot-matrix displays. It is the generalised successor of the fixed 8x8 scanner. The block accepts a full frame through a valid/ready handshake into a pending buffer and swaps it into the display buffer only at frame boundaries, so a refresh never tears. It scans ROWS one-hot rows, holds each row for a programmable dwell time, and applies per-row PWM brightness.

Parameters:
ROWS, 8, number of rows (row output width), >=2
COLS, 8, number of columns (column output width), >=1
DWELL_LOG2, 8, dwell per row = 2^DWELL_LOG2 clocks, >= PWM_BITS
PWM_BITS, 4, brightness resolution
BLANK_CYCLES, 2, anti-ghost blank cycles at row start; used only with MATRIX_SCAN_BLANK_EN, < 2^DWELL_LOG2

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
frame_data  in  ROWS*COLS  frame; row r = bits [r*COLS +: COLS], column bit 0 = lowest bit of the slice
frame_valid  in  1  frame_data valid
frame_ready  out  1  pending buffer empty; transfer occurs on valid&&ready at a rising edge
brightness  in  PWM_BITS  duty level, sampled at each row start
oe  in  1  scan enable
row  out  ROWS  one-hot row drive, registered
column  out  COLS  column drive, registered
frame_start  out  1  one-cycle pulse when row index becomes 0

Behaviour:
- Reset (synchronous, active-high):
  - row=0, column=0, frame_start=0.
  - State IDLE; row_idx=0; dwell_cnt=0.
  - Display and pending buffers cleared; pending_full=0.
  - frame_ready=0 while reset is high (frame_ready = !pending_full && !reset).
- Handshake:
  - frame_valid&&frame_ready at an edge: pending<=frame_data, pending_full<=1.
  - frame_data may change freely while ready=0; it is not sampled then.
- States: IDLE, SCAN.
- IDLE:
  - oe sampled 1: go to SCAN; row_idx=0; dwell_cnt=0; frame_start<=1.
  - If pending_full, display<=pending and pending_full<=0 on every IDLE edge, independent of oe.
  - row and column are held at 0.
- SCAN:
  - dwell_cnt increments every clock and wraps at 2^DWELL_LOG2-1.
  - On wrap, row_idx increments.
  - At row_idx=ROWS-1 with dwell wrap (frame boundary):
    - row_idx<=0 and frame_start<=1.
    - If pending_full: display<=pending, pending_full<=0.
  - A capture on the same edge as a boundary with pending empty is held for the next boundary.
  - oe sampled 0: go to IDLE on the next edge; row_idx, dwell_cnt, row and column are zeroed on that same edge. Display and pending buffers are retained.
- Output latency: row and column at edge k+1 are computed from row_idx, dwell_cnt and the latched brightness after edge k (one-cycle latency).
- PWM:
  - Let lvl = brightness latched when dwell_cnt=0.
  - The row is on when dwell_cnt[DWELL_LOG2-1 -: PWM_BITS] < lvl.
  - When on: row = 1<<row_idx and column = display[row_idx*COLS +: COLS]. When off: both outputs are 0.
  - lvl=0 means fully off; the maximum lvl gives a duty of (2^PWM_BITS-1)/2^PWM_BITS.
- Brightness changes mid-row take effect at the next row start only.

Optional Feature:
MATRIX_SCAN_BLANK_EN
- Defined: row and column are additionally forced to 0 while dwell_cnt < BLANK_CYCLES in every row, to suppress ghosting. The PWM comparison is unchanged, so the on-window shrinks by BLANK_CYCLES.
- Undefined: no blanking logic is generated, and BLANK_CYCLES is ignored.

Test Plan:
All scenarios use ROWS=8, COLS=8, DWELL_LOG2=4, PWM_BITS=2, with the macro undefined unless stated.
1. Reset held 3 cycles -> row=0, column=0 and frame_ready=0 throughout; frame_ready=1 the first cycle after reset is released; no frame_start pulse.
2. Load 0x8040201008040201 in IDLE, brightness=3, then raise oe:
   - frame_start pulses once.
   - row=0x01 and column=0x01 for 12 cycles, then 0 for 4 cycles.
   - Then row=0x02, column=0x02, and so on; frame_start pulses every 128 cycles.
3. While scanning frame A=all-0x0F, load B=all-0xF0 during row 3:
   - frame_ready drops the cycle after capture.
   - A second frame_valid is not accepted.
   - Rows 3-7 still show 0x0F; row 0 after the boundary shows 0xF0; frame_ready returns 1.
4. brightness=0 while scanning -> row=0 and column=0 continuously; frame_start still pulses every 128 cycles. Change to 2 mid-row 4 -> row 5 is on for 8 of 16 cycles.
5. Drop oe during row 5 -> outputs 0 on the next edge. Reassert oe -> scan restarts at row 0 with a frame_start pulse, and the display content is unchanged.
6. MATRIX_SCAN_BLANK_EN defined, BLANK_CYCLES=2, brightness=3 -> each row is on only for dwell 2..11 (10 cycles).
